// File: rtl/gpio_debounce.sv
// Per-channel GPIO debouncer: 2-flop sync, hold counter, optional edge pulses/sticky flags/irq (GPIO_DEBOUNCE_EDGE_EN).
// Latency: o_level DEBOUNCE_CYCLES+2 edges after pin change; pulses with o_level, flags +1, o_irq_n +2.
// Backpressure: none; every input edge is consumed, events are held in sticky flags until cleared.
module gpio_debounce #(
  parameter int   CHANNELS        = 4,
  parameter int   DEBOUNCE_CYCLES = 48000,
  parameter int   CNT_WIDTH       = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [CHANNELS-1:0] i_pins,
  output logic [CHANNELS-1:0] o_level,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall,
  output logic [CHANNELS-1:0] o_flags,
  input  logic [CHANNELS-1:0] i_flag_clear,
  output logic                o_irq_n
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] sync_meta;
  logic [CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0] level_load;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_meta <= {CHANNELS{RESET_LEVEL}};
      sync_q    <= {CHANNELS{RESET_LEVEL}};
    end else begin
      sync_meta <= i_pins;
      sync_q    <= sync_meta;
    end
  end

  // Counter tracks consecutive cycles the synced pin disagrees with o_level; saturates by reloading on the flip.
  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt;
    logic                 differs;

    assign differs       = sync_q[n] != o_level[n];
    assign level_load[n] = differs && (cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        cnt <= '0;
      end else if (!differs || level_load[n]) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_level <= {CHANNELS{RESET_LEVEL}};
    end else begin
      o_level <= o_level ^ level_load;
    end
  end

`ifdef GPIO_DEBOUNCE_EDGE_EN
  // Pulses register alongside o_level so they line up with the cycle showing the new value.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rise  <= '0;
      o_fall  <= '0;
      o_flags <= '0;
      o_irq_n <= 1'b1;
    end else begin
      o_rise  <= level_load & sync_q;
      o_fall  <= level_load & ~sync_q;
      o_flags <= (o_flags & ~i_flag_clear) | o_rise | o_fall;
      o_irq_n <= ~|o_flags;
    end
  end
`else
  logic unused_flag_clear;

  assign unused_flag_clear = ^i_flag_clear;
  assign o_rise  = '0;
  assign o_fall  = '0;
  assign o_flags = '0;
  assign o_irq_n = 1'b1;
`endif

endmodule

// File: doc/gpio_debounce.md
GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent input channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 48000, consecutive synchronized clocks a new level must hold (1 ms at 48 MHz).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, debounce counter width; legal range is 1 <= DEBOUNCE_CYCLES <= 2^CNT_WIDTH.
REQ-004 SHALL have parameter RESET_LEVEL, default 1'b0, value loaded into every o_level bit at reset.
REQ-005 i_clk  input  1  sole clock; all state on rising edge.
REQ-006 i_reset_n  input  1  asynchronous, active-low reset.
REQ-007 i_pins  input  CHANNELS  raw asynchronous pad inputs, e.g. touch pads.
REQ-008 o_level  output  CHANNELS  debounced level; feeds MCU GPIO input bits.
REQ-009 o_rise  output  CHANNELS  one-cycle pulse on a debounced 0->1 transition.
REQ-010 o_fall  output  CHANNELS  one-cycle pulse on a debounced 1->0 transition.
REQ-011 o_flags  output  CHANNELS  sticky per-channel event flags, either edge.
REQ-012 i_flag_clear  input  CHANNELS  write-1-to-clear strobe for o_flags.
REQ-013 o_irq_n  output  1  active-low, low while any o_flags bit is set; registered.

Function
REQ-014 Each i_pins bit SHALL pass through a two-flop synchronizer before any other logic; sync value s[n].
REQ-015 Per channel, when s[n] == o_level[n] the counter SHALL load 0.
REQ-016 When s[n] != o_level[n] and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-017 When s[n] != o_level[n] and counter == DEBOUNCE_CYCLES-1, o_level[n] SHALL load s[n] and the counter SHALL load 0.
REQ-018 A clean pin transition SHALL reach o_level exactly DEBOUNCE_CYCLES+2 rising edges after the first edge sampling the new pin value.
REQ-019 Any excursion shorter than DEBOUNCE_CYCLES consecutive synchronized cycles SHALL leave o_level unchanged and restart the count.
REQ-020 With DEBOUNCE_CYCLES=1, o_level SHALL follow s with one cycle of delay.
REQ-021 o_rise[n] and o_fall[n] SHALL be registered; each asserts for exactly the one cycle in which o_level[n] shows the new value.
REQ-022 o_flags[n] SHALL set on the clock after o_rise[n] or o_fall[n] and hold until cleared.
REQ-023 i_flag_clear[n]=1 SHALL clear o_flags[n] on the next edge; if set and clear coincide, set SHALL win.
REQ-024 o_irq_n SHALL equal ~|o_flags delayed one cycle.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be captured.
REQ-026 Counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-027 While i_reset_n=0: synchronizer flops=RESET_LEVEL, o_level=RESET_LEVEL, counters=0, o_rise=o_fall=0, o_flags=0, o_irq_n=1.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count; no pulse or flag SHALL result from the interrupted transition.
REQ-029 If pins differ from RESET_LEVEL after release, the normal debounce SHALL apply and produce the corresponding edge pulse and flag.

Configuration
REQ-030 Macro GPIO_DEBOUNCE_EDGE_EN defined: edge pulses, sticky flags and o_irq_n SHALL behave per REQ-021..REQ-024.
REQ-031 Macro GPIO_DEBOUNCE_EDGE_EN undefined: ports SHALL remain; o_rise=o_fall=o_flags=0, o_irq_n=1 constant, i_flag_clear ignored, and no edge/flag registers synthesized; o_level behaviour unchanged.

Verification (CHANNELS=4, DEBOUNCE_CYCLES=4, RESET_LEVEL=0, macro defined unless noted)
REQ-032 Reset with i_pins=4'b0000 -> o_level=0, o_flags=0, o_irq_n=1 at and after release.
REQ-033 i_pins[0] 0->1 held -> o_level[0]=1 exactly 6 edges later, o_rise[0] high that one cycle, o_flags[0]=1 next cycle, o_irq_n=0 one cycle after that.
REQ-034 i_pins[1] pulsed high for 3 cycles -> o_level[1], o_rise[1], o_flags[1] stay 0.
REQ-035 o_flags=4'b0001, i_flag_clear=4'b0001 same cycle as new o_fall[0] -> o_flags[0] stays 1; clear next cycle alone -> o_flags=0, o_irq_n=1 one cycle later.
REQ-036 i_pins[2] high 2 cycles into debounce then i_reset_n low -> after release with pin low, no o_rise[2], o_flags[2]=0.
REQ-037 Macro undefined, i_pins[3] 0->1 held -> o_level[3]=1 after 6 edges; o_rise, o_flags stay 0, o_irq_n stays 1.
